seq_alu: RTL and testbench

- Parametrised, registered successor to the combinational 2-bit-opcode ALU.
- Widens the datapath to WIDTH and extends the op set to XOR, SLT, shifts and an iterative unsigned multiply/divide.
- Wraps every operation in a valid/ready handshake with registered results and NZCV flags.
- Sits between decode/issue and writeback. Single-cycle ops complete in 1 cycle; MUL/DIV occupy the unit for WIDTH cycles.

---
 rtl/seq_alu.sv | 236 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered WIDTH-bit ALU with valid/ready handshake and NZCV flags; SEQ_ALU_MULDIV_EN enables iterative MUL/DIVU/REMU
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             n_q;
    logic             z_q;
    logic             c_q;
    logic             v_q;
    logic             out_valid_q;
    logic             in_ready_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = n_q;
    assign zero      = z_q;
    assign carry     = c_q;
    assign overflow  = v_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    // Single-cycle datapath, evaluated on the live inputs so the result can be registered at the accept edge
    always_comb begin
        add_w = {1'b0, src_a} + {1'b0, src_b};
        sub_w = {1'b0, src_a} - {1'b0, src_b};
        shamt = src_b[SHW-1:0];
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_w[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_w[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: alu_r = src_a & src_b;
            OP_OR:  alu_r = src_a | src_b;
            OP_XOR: alu_r = src_a ^ src_b;
            OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL: alu_r = src_a << shamt;
            OP_SRL: alu_r = src_a >> shamt;
            OP_SRA: alu_r = $unsigned($signed(src_a) >>> shamt);
            default: begin
                alu_r = '0;
                alu_c = 1'b0;
                alu_v = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // acc_q is the product high half / partial remainder; lo_q is multiplier / dividend-then-quotient;
    // opnd_q holds the multiplicand (MUL) or divisor (DIVU/REMU)
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       mop_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] fin_r;
    logic             fin_c;
    logic             fin_v;
    logic             is_muldiv;

    assign is_muldiv = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

    // One shift-add or restoring-subtract step; a zero divisor never borrows, giving all-ones quotient and remainder A
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (mop_q == OP_MUL) begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = div_shift[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Select the final result and C/V from the last step's outputs
    always_comb begin
        fin_r = lo_d;
        fin_c = 1'b0;
        fin_v = 1'b0;
        case (mop_q)
            OP_MUL:  fin_c = |acc_d;
            OP_DIVU: fin_v = (opnd_q == '0);
            default: begin
                fin_r = acc_d;
                fin_v = (opnd_q == '0);
            end
        endcase
    end
`endif

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
            cnt_q       <= '0;
            mop_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
                        if (is_muldiv) begin
                            state_q <= S_BUSY;
                            cnt_q   <= '0;
                            mop_q   <= op;
                            acc_q   <= '0;
                            lo_q    <= (op == OP_MUL) ? src_b : src_a;
                            opnd_q  <= (op == OP_MUL) ? src_a : src_b;
                        end else
`endif
                        begin
                            state_q     <= S_DONE;
                            result_q    <= alu_r;
                            n_q         <= alu_r[WIDTH-1];
                            z_q         <= (alu_r == '0);
                            c_q         <= alu_c;
                            v_q         <= alu_v;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= S_DONE;
                        result_q    <= fin_r;
                        n_q         <= fin_r[WIDTH-1];
                        z_q         <= (fin_r == '0);
                        c_q         <= fin_c;
                        v_q         <= fin_v;
                        out_valid_q <= 1'b1;
                    end
`else
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with directed vectors
module tb_seq_alu;

    localparam int W = 32;

`ifdef SEQ_ALU_MULDIV_EN
    localparam int MD_LAT = 33;
`else
    localparam int MD_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         carry;
    logic         overflow;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          c0;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: each new result presentation pops one expectation
    logic prev_ov = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.r);
                check({mon_e.name, "_nzcv"}, {28'd0, negative, zero, carry, overflow}, {28'd0, mon_e.f});
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.c0), 32'(mon_e.lat));
            end
        end
        prev_ov = out_valid;
    end

    task automatic issue(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f, input int lat);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.name = name; e.r = r; e.f = f; e.lat = lat; e.c0 = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Multiply/divide vector; without the feature these ops act as undefined opcodes
    task automatic md(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [3:0] f);
`ifdef SEQ_ALU_MULDIV_EN
        issue(name, o, a, b, r, f, MD_LAT);
`else
        issue(name, o, a, b, 32'h0, 4'b0100, MD_LAT);
`endif
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0 || out_valid) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int bad;
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_nzcv", {28'd0, negative, zero, carry, overflow}, 32'h0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // flags order: {N,Z,C,V}
        issue("add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1);
        issue("sub_eq",   4'b0001, 32'd5,        32'd5,        32'h00000000, 4'b0100, 1);
        issue("sub_brw",  4'b0001, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1010, 1);
        issue("slt_neg",  4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
        issue("sra_4",    4'b1000, 32'h80000000, 32'd4,        32'hF8000000, 4'b1000, 1);
        issue("and",      4'b0010, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 4'b1000, 1);
        issue("or",       4'b0011, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 4'b0000, 1);
        issue("sll_31",   4'b0110, 32'h00000001, 32'h0000003F, 32'h80000000, 4'b1000, 1);
        issue("srl_31",   4'b0111, 32'h80000000, 32'd31,       32'h00000001, 4'b0000, 1);
        issue("undef_c",  4'b1100, 32'd5,        32'd3,        32'h00000000, 4'b0100, 1);
        issue("undef_f",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1);
        drain();

        // MUL with in_valid pulses while busy
        md("mul_ovf", 4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110);
        bad = 0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            if (!out_valid) begin
                if (in_ready) bad++;
                op = 4'b0000; src_a = 32'd1; src_b = 32'd1;
                in_valid = t[0];
            end
            t++;
        end
        in_valid = 1'b0;
        check("mul_busy_in_ready", 32'(bad), 32'd0);
        drain();

        md("mul_max",  4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0010);
        md("mul_3x5",  4'b1001, 32'd3,        32'd5,        32'd15,       4'b0000);
        md("divu",     4'b1010, 32'd100,      32'd7,        32'd14,       4'b0000);
        md("remu",     4'b1011, 32'd100,      32'd7,        32'd2,        4'b0000);
        md("divu_z",   4'b1010, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b1001);
        md("remu_z",   4'b1011, 32'd9,        32'd0,        32'd9,        4'b0001);
        drain();

        // Backpressure on a single-cycle result
        out_ready = 1'b0;
        issue("xor_bp", 4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'b0000, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result", result, 32'h0F0FF0F0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        drain();

        // Reset in the middle of a multiply
`ifdef SEQ_ALU_MULDIV_EN
        @(negedge clk);
        op = 4'b1001; src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
`else
        issue("rst_mul", 4'b1001, 32'd3, 32'd5, 32'h0, 4'b0100, 1);
`endif
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_nzcv", {28'd0, negative, zero, carry, overflow}, 32'h0);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_rel_out_valid", {31'd0, out_valid}, 32'd0);
        issue("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
        issue("add_carry",     4'b0000, 32'hFFFFFFFF, 32'd1, 32'h0, 4'b0110, 1);
        drain();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
